// File: rtl/dmem_stall_ctrl_if.sv
// Bundle between the EX/MEM pipeline stage, the stall sequencer and the data memory.
// Handshake: ex_rd/ex_wr are valid and held by the frozen pipeline until done; stall is the
// inverse of ready. mem_req is valid with mem_we/mem_addr/mem_wdata held stable until mem_ack.
interface dmem_stall_ctrl_if #(
  parameter int DW = 16
);
  logic          ex_rd;
  logic          ex_wr;
  logic [DW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata;
  logic          stall;
  logic          done;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  ex_rd, ex_wr, ex_addr, ex_wdata, mem_ack, mem_rdata,
    output stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ex_rd, ex_wr, ex_addr, ex_wdata, mem_ack, mem_rdata,
    input  stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// Data-memory access sequencer at EX/MEM: holds the pipeline during a multi-cycle access.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects accesses with ex_addr[0]=1 as errors.
module dmem_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_stall_ctrl_if.master     bus,
  output logic [1:0]            dbg_state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          done_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          access;
  logic          reject;

  assign access = bus.ex_rd ^ bus.ex_wr;

  // Accesses that complete with an error without ever reaching memory.
`ifdef DMEM_ALIGN_CHECK_EN
  assign reject = (bus.ex_rd & bus.ex_wr) | (access & bus.ex_addr[0]);
`else
  assign reject = bus.ex_rd & bus.ex_wr;
`endif

  // No path from mem_ack: only state and the EX/MEM request bits.
  always_comb begin
    bus.stall = ((state == IDLE) && (bus.ex_rd || bus.ex_wr)) || (state == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (reject) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (access) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.ex_wr;
            mem_addr_q  <= bus.ex_addr;
            mem_wdata_q <= bus.ex_wdata;
            timer       <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          // An ack on the final timer cycle still wins over the timeout.
          if (bus.mem_ack) begin
            if (!mem_we_q) rdata_q <= bus.mem_rdata;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl: access-level model fills an expected queue per cycle,
// one compare process checks it, and literal expectations pin the model per scenario.
module tb_dmem_stall_ctrl;

  localparam int TIMEOUT = 16;
  localparam int DW      = 16;

  typedef struct packed {
    logic          stall;
    logic          done;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] rdata;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
  } exp_t;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  dmem_stall_ctrl_if #(.DW(DW)) bus ();

  dmem_stall_ctrl #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [$bits(exp_t)-1:0] exp_q[$];
  exp_t   cmp_e;
  int     checks = 0;
  int     errors = 0;
  int     cnt_stall, cnt_req, cnt_done;

  // Architectural values the model expects to be held between accesses.
  logic          m_err   = 1'b0;
  logic          m_we    = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic st, input logic dn, input logic rq);
    exp_t e;
    e.stall     = st;
    e.done      = dn;
    e.mem_req   = rq;
    e.err       = m_err;
    e.mem_we    = m_we;
    e.rdata     = m_rdata;
    e.mem_addr  = m_addr;
    e.mem_wdata = m_wdata;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      cmp_e = exp_t'(exp_q.pop_front());
      chk("stall",     {15'd0, bus.stall},   {15'd0, cmp_e.stall});
      chk("done",      {15'd0, bus.done},    {15'd0, cmp_e.done});
      chk("mem_req",   {15'd0, bus.mem_req}, {15'd0, cmp_e.mem_req});
      chk("mem_we",    {15'd0, bus.mem_we},  {15'd0, cmp_e.mem_we});
      chk("mem_addr",  bus.mem_addr,         cmp_e.mem_addr);
      chk("mem_wdata", bus.mem_wdata,        cmp_e.mem_wdata);
      if (cmp_e.done) begin
        chk("err",   {15'd0, bus.err}, {15'd0, cmp_e.err});
        chk("rdata", bus.rdata,        cmp_e.rdata);
      end
      cnt_stall += int'(bus.stall);
      cnt_req   += int'(bus.mem_req);
      cnt_done  += int'(bus.done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rd, input logic wr, input logic [DW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic ack, input logic [DW-1:0] mrd,
                     input exp_t e);
    @(negedge clk);
    bus.ex_rd     = rd;
    bus.ex_wr     = wr;
    bus.ex_addr   = addr;
    bus.ex_wdata  = wdata;
    bus.mem_ack   = ack;
    bus.mem_rdata = mrd;
    exp_q.push_back(e);
  endtask

  // One instruction: ack_at is the REQ cycle (1-based) carrying mem_ack; 0 means never,
  // TIMEOUT+1 means an ack arriving one cycle after the timeout.
  task automatic access(input logic rd, input logic wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input int ack_at, input logic [DW-1:0] data);
    logic bad;
    int   n;
    bad = rd & wr;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((rd ^ wr) && addr[0]) bad = 1'b1;
`endif
    cnt_stall = 0;
    cnt_req   = 0;
    cnt_done  = 0;
    n = 0;
    cyc(rd, wr, addr, wdata, 1'b0, 16'h0000, mk(1'b1, 1'b0, 1'b0));
    if (bad) begin
      m_err = 1'b1;
    end else begin
      n = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
      m_we = wr; m_addr = addr; m_wdata = wdata;
      // EX inputs wander during REQ to prove the memory side holds its captured values.
      for (int j = 1; j <= n; j++)
        cyc(rd, wr, ~addr, ~wdata, (j == ack_at), (j == ack_at) ? data : ~data,
            mk(1'b1, 1'b0, 1'b1));
      if (ack_at == n) begin
        m_err = 1'b0;
        if (rd) m_rdata = data;
      end else begin
        m_err = 1'b1;
      end
    end
    cyc(rd, wr, addr, wdata, (!bad && ack_at == TIMEOUT + 1), 16'hDEAD, mk(1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, mk(1'b0, 1'b0, 1'b0));
    #3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.ex_rd = 1'b0; bus.ex_wr = 1'b0; bus.ex_addr = '0; bus.ex_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    cnt_stall = 0; cnt_req = 0; cnt_done = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall",     {15'd0, bus.stall},   16'h0000);
    chk("rst_done",      {15'd0, bus.done},    16'h0000);
    chk("rst_err",       {15'd0, bus.err},     16'h0000);
    chk("rst_mem_req",   {15'd0, bus.mem_req}, 16'h0000);
    chk("rst_mem_we",    {15'd0, bus.mem_we},  16'h0000);
    chk("rst_rdata",     bus.rdata,            16'h0000);
    chk("rst_mem_addr",  bus.mem_addr,         16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata,        16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Fastest load.
    access(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'hBEEF);
    chk("t1_stall_cycles", 16'(cnt_stall), 16'd2);
    chk("t1_req_cycles",   16'(cnt_req),   16'd1);
    chk("t1_done_cycles",  16'(cnt_done),  16'd1);
    chk("t1_rdata",        bus.rdata,      16'hBEEF);
    chk("t1_err",          {15'd0, bus.err}, 16'h0000);

    // Store with ack after 5 REQ cycles; rdata must keep BEEF.
    access(1'b0, 1'b1, 16'h0040, 16'h1234, 5, 16'h7777);
    chk("t2_stall_cycles", 16'(cnt_stall), 16'd6);
    chk("t2_req_cycles",   16'(cnt_req),   16'd5);
    chk("t2_mem_we",       {15'd0, bus.mem_we}, 16'h0001);
    chk("t2_mem_wdata",    bus.mem_wdata,  16'h1234);
    chk("t2_rdata_kept",   bus.rdata,      16'hBEEF);
    chk("t2_err",          {15'd0, bus.err}, 16'h0000);

    // Load timeout, late ack in the DONE cycle is dropped.
    access(1'b1, 1'b0, 16'h0200, 16'h0000, TIMEOUT + 1, 16'hCAFE);
    chk("t3_req_cycles",   16'(cnt_req),   16'd16);
    chk("t3_stall_cycles", 16'(cnt_stall), 16'd17);
    chk("t3_err",          {15'd0, bus.err}, 16'h0001);
    chk("t3_rdata_kept",   bus.rdata,      16'hBEEF);

    // Ack on the last permitted cycle beats the timeout.
    access(1'b1, 1'b0, 16'h0404, 16'h0000, TIMEOUT, 16'h1357);
    chk("t3b_req_cycles",  16'(cnt_req),   16'd16);
    chk("t3b_err",         {15'd0, bus.err}, 16'h0000);
    chk("t3b_rdata",       bus.rdata,      16'h1357);

    // Illegal load+store.
    access(1'b1, 1'b1, 16'h0300, 16'h0055, 1, 16'h1111);
    chk("t4_req_cycles",   16'(cnt_req),   16'd0);
    chk("t4_stall_cycles", 16'(cnt_stall), 16'd1);
    chk("t4_done_cycles",  16'(cnt_done),  16'd1);
    chk("t4_err",          {15'd0, bus.err}, 16'h0001);

    // Reset in the 3rd REQ cycle; the pipeline flush drops ex_rd with it.
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, mk(1'b1, 1'b0, 1'b0));
    m_we = 1'b0; m_addr = 16'h0010; m_wdata = 16'h0000;
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, mk(1'b1, 1'b0, 1'b1));
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, mk(1'b1, 1'b0, 1'b1));
    @(negedge clk);
    #3;
    chk("t5_req_before_rst", {15'd0, bus.mem_req}, 16'h0001);
    rst = 1'b0;
    bus.ex_rd = 1'b0;
    #1;
    chk("t5_req_async",   {15'd0, bus.mem_req}, 16'h0000);
    chk("t5_stall_async", {15'd0, bus.stall},   16'h0000);
    chk("t5_addr_async",  bus.mem_addr,         16'h0000);
    m_err = 1'b0; m_we = 1'b0; m_rdata = '0; m_addr = '0; m_wdata = '0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, mk(1'b0, 1'b0, 1'b0));
    access(1'b1, 1'b0, 16'h0022, 16'h0000, 2, 16'h5A5A);
    chk("t5_reload_rdata", bus.rdata, 16'h5A5A);
    chk("t5_reload_req",   16'(cnt_req), 16'd2);

    // Odd address load.
    access(1'b1, 1'b0, 16'h0003, 16'h0000, 1, 16'h0BAD);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("t6_req_cycles", 16'(cnt_req), 16'd0);
    chk("t6_err",        {15'd0, bus.err}, 16'h0001);
    chk("t6_rdata_kept", bus.rdata, 16'h5A5A);
`else
    chk("t6_req_cycles", 16'(cnt_req), 16'd1);
    chk("t6_mem_addr",   bus.mem_addr, 16'h0003);
    chk("t6_rdata",      bus.rdata, 16'h0BAD);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
